// File: rtl/led_pattern_counter.sv
// LED pattern counter: a prescaler produces a step strobe, and each step advances
// an N_LED-bit display register in up, down, bounce-scanner or hold mode.
module led_pattern_counter #(
  parameter int N_LED   = 8,
  parameter int PRE_DIV = 16777216
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             LOAD,
  input  logic [N_LED-1:0] LOAD_VAL,
  output logic [N_LED-1:0] LEDG,
  output logic             TICK
);

  localparam int              PRE_W    = ($clog2(PRE_DIV) < 1) ? 1 : $clog2(PRE_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);

  typedef enum logic [1:0] {
    M_UP     = 2'b00,
    M_DOWN   = 2'b01,
    M_BOUNCE = 2'b10,
    M_HOLD   = 2'b11
  } mode_e;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [N_LED-1:0] disp_q, disp_d;
  logic             dir_q, dir_d;
  logic             tick_q, tick_d;
  logic             step;
  logic             one_hot;

  assign step    = EN && (pre_q == PRE_LAST);
  assign one_hot = (disp_q != '0) && ((disp_q & (disp_q - N_LED'(1))) == '0);

  always_comb begin
    pre_d  = pre_q;
    disp_d = disp_q;
    dir_d  = dir_q;
    tick_d = 1'b0;
    if (LOAD) begin
      // Load restarts the step interval and the scanner direction.
      disp_d = LOAD_VAL;
      pre_d  = '0;
      dir_d  = 1'b0;
    end else begin
      if (EN) pre_d = step ? '0 : pre_q + PRE_W'(1);
      if (step) begin
        tick_d = 1'b1;
        case (mode_e'(MODE))
          M_UP:   disp_d = disp_q + N_LED'(1);
          M_DOWN: disp_d = disp_q - N_LED'(1);
          M_BOUNCE: begin
            // Anything that is not a single lit LED restarts the scan at bit 0.
            if (!one_hot) begin
              disp_d = N_LED'(1);
              dir_d  = 1'b0;
            end else if (!dir_q) begin
              if (disp_q[N_LED-1]) begin
                disp_d = disp_q >> 1;
                dir_d  = 1'b1;
              end else begin
                disp_d = disp_q << 1;
              end
            end else begin
              if (disp_q[0]) begin
                disp_d = disp_q << 1;
                dir_d  = 1'b0;
              end else begin
                disp_d = disp_q >> 1;
              end
            end
          end
          default: disp_d = disp_q;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pre_q  <= '0;
      disp_q <= '0;
      dir_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      disp_q <= disp_d;
      dir_q  <= dir_d;
      tick_q <= tick_d;
    end
  end

  assign LEDG = disp_q;
  assign TICK = tick_q;

endmodule

// File: doc/led_pattern_counter.md
# led_pattern_counter

Parametrised successor to the board's free-running LED counter. A prescaler divides CLOCK_50 down to a visible step rate. On each step, an N_LED-bit display register advances according to a selectable mode: binary up, binary down, bouncing one-hot scanner, or hold. The block supports a synchronous load and emits a step strobe. It sits directly between the board clock/switches/keys and the green LED bank, and its TICK output is available to other display logic.

## Interface
- N_LED, 8: display width in bits; legal range ≥ 2.
- PRE_DIV, 16777216: prescaler divide ratio; one step per PRE_DIV enabled cycles; legal range ≥ 1.
- PRE_W, derived as max(1, clog2(PRE_DIV)): prescaler counter width; not overridden.

- CLOCK_50  in  1  sole clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- EN  in  1  count enable; low freezes the prescaler and the display.
- MODE  in  2  00 up, 01 down, 10 bounce, 11 hold.
- LOAD  in  1  synchronous load request; level-sensitive.
- LOAD_VAL  in  N_LED  value written to the display on load.
- LEDG  out  N_LED  display register, driven directly from a flop.
- TICK  out  1  registered strobe, high for the one cycle in which LEDG shows a newly stepped value.

## Operation
- **State:**
  - pre: PRE_W bits, reset 0.
  - disp: N_LED bits, reset 0.
  - dir: 1 bit, 0 = toward MSB, reset 0.
  - TICK: reset 0.
- **Step condition:** step = EN && (pre == PRE_DIV-1).
  - When EN is high: pre <= step ? 0 : pre+1.
  - When EN is low: pre holds.
  - With PRE_DIV = 1, pre is constantly 0 and step = EN.
- **Priority, evaluated each rising edge:**
  1. LOAD: disp <= LOAD_VAL; pre <= 0; dir <= 0; TICK <= 0. Applies regardless of EN.
  2. step: disp updates per MODE (below); TICK <= 1.
  3. Otherwise: disp and dir hold; TICK <= 0.
- **MODE 00 (up):** disp <= disp + 1, modulo 2^N_LED; all-ones wraps to 0.
- **MODE 01 (down):** disp <= disp - 1, modulo 2^N_LED; 0 wraps to all-ones.
- **MODE 10 (bounce):**
  - If disp is not one-hot (zero, or two or more bits set): disp <= 1, dir <= 0.
  - Else if dir = 0:
    - disp[N_LED-1] set: disp <= disp >> 1, dir <= 1.
    - otherwise: disp <= disp << 1.
  - Else (dir = 1):
    - disp[0] set: disp <= disp << 1, dir <= 0.
    - otherwise: disp <= disp >> 1.
  - Endpoints are therefore shown for exactly one step each. Period = 2·(N_LED-1) steps.
- **MODE 11 (hold):** disp holds, but TICK still pulses and the prescaler keeps running.
- **MODE changes:**
  - MODE is sampled only on step edges. A change between steps takes effect at the next step.
  - dir is preserved across mode changes; only load, reset, or bounce normalisation modify it.
- **Arithmetic:** all arithmetic is unsigned and truncated to the target width. No X-propagation from uninitialised state; every flop is reset.

## Timing
- Reset: asynchronous assertion forces LEDG = 0, TICK = 0, pre = 0, dir = 0 immediately. The first step occurs PRE_DIV enabled cycles after the first rising edge following deassertion.
- Reset mid-step or mid-bounce: all state is lost, and the sequence restarts from 0 after release.
- Step latency: LEDG and TICK change on the same edge. TICK is high for exactly one cycle per step, so the minimum TICK spacing is PRE_DIV cycles.
- Load latency: LEDG = LOAD_VAL one cycle after LOAD is sampled high.
  - A held LOAD keeps re-loading and keeps pre at 0, so no steps occur.
  - After LOAD falls, the next step comes PRE_DIV enabled cycles later.
- LOAD and step on the same edge: load wins and TICK stays 0.
- EN deasserted for k cycles: the step schedule is delayed by exactly k cycles, and no prescaler progress is lost.

## Test plan
- **Reset/up count:** N_LED=4, PRE_DIV=4, EN=1, MODE=00.
  - Release reset: LEDG = 0.
  - TICK pulses at cycles 4, 8, 12, …
  - LEDG steps 1, 2, …, 15, 0. Wrap occurs on the 16th step.
- **Down wrap and EN freeze:** N_LED=4, PRE_DIV=4, MODE=01, starting from 0.
  - First step: LEDG = 15.
  - Drop EN for 10 cycles mid-interval: the next TICK is delayed by exactly 10 cycles, and LEDG is unchanged meanwhile.
- **Bounce:** N_LED=4, PRE_DIV=1, MODE=10, starting from 0.
  - LEDG sequence: 1, 2, 4, 8, 4, 2, 1, 2, …
  - Period is 6 steps.
  - LOAD_VAL=4'b0110 then step: LEDG = 1.
- **Load priority:** N_LED=4, PRE_DIV=4. Assert LOAD with LOAD_VAL=4'hA on the same edge as a step.
  - LEDG = A and TICK = 0.
  - Next TICK arrives 4 cycles after LOAD drops.
  - In MODE=00 the next value is B.
- **Hold and mode switch:** N_LED=4, PRE_DIV=4, MODE=11.
  - TICK continues and LEDG stays constant.
  - Switch to 00 between steps: increments begin at the next step, with no extra step.
- **Async reset mid-run:** pull RESET_N low between clock edges.
  - LEDG = 0 and TICK = 0 before the next edge.
  - After release, the first TICK comes after PRE_DIV cycles.
